// File: rtl/qq_port_arbiter.sv
// Round-robin front end that shares one quickq root among N requesters,
// spaces root operations GAP cycles apart and returns tagged dequeue results.
module qq_port_arbiter #(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int CAP    = 16,
    parameter int GAP    = 2,
    parameter int RD_LAT = 2,
    parameter int IDW    = $clog2(N),
    parameter int CW     = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_op,
    input  logic [N*W-1:0]   req_key,
    output logic [N-1:0]     gnt,
    output logic             q_enq_o,
    output logic             q_deq_o,
    output logic [W-1:0]     q_key_o,
    input  logic [W-1:0]     q_key_i,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_key,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int CCW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

    state_t                   state;
    logic [IDW-1:0]           ptr;
    logic [IDW-1:0]           win_id;
    logic                     win_op;
    logic [CCW-1:0]           cool_cnt;
    logic [N-1:0]             elig;
    logic                     arb_ok;
    logic [IDW-1:0]           arb_id;
    logic [IDW-1:0]           ptr_next;
    logic                     issue_deq;
    logic [RD_LAT:1]          vld_pipe;
    logic [RD_LAT:1][IDW-1:0] id_pipe;
    logic [IDW-1:0]           id_hold;
    logic [W-1:0]             key_hold;

    assign full  = (count == CW'(CAP));
    assign empty = (count == '0);

    // Blocked ops simply drop out of the search, so they never stall others.
    always_comb begin
        for (int i = 0; i < N; i++)
            elig[i] = req[i] & (req_op[i] ? ~empty : ~full);
    end

    always_comb begin
        int idx;
        idx    = 0;
        arb_ok = 1'b0;
        arb_id = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!arb_ok && elig[idx]) begin
                arb_ok = 1'b1;
                arb_id = IDW'(idx);
            end
        end
        ptr_next = IDW'((int'(arb_id) + 1) % N);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            win_id   <= '0;
            win_op   <= 1'b0;
            cool_cnt <= '0;
            count    <= '0;
            gnt      <= '0;
            q_enq_o  <= 1'b0;
            q_deq_o  <= 1'b0;
            q_key_o  <= '0;
        end else begin
            gnt     <= '0;
            q_enq_o <= 1'b0;
            q_deq_o <= 1'b0;
            q_key_o <= '0;
            case (state)
                ISSUE: begin
                    count    <= win_op ? count - CW'(1) : count + CW'(1);
                    cool_cnt <= CCW'(GAP - 1);
                    state    <= COOL;
                end
                default: begin
                    if (state == COOL && cool_cnt != CCW'(1)) begin
                        cool_cnt <= cool_cnt - CCW'(1);
                    end else if (arb_ok) begin
                        state   <= ISSUE;
                        win_id  <= arb_id;
                        win_op  <= req_op[arb_id];
                        ptr     <= ptr_next;
                        gnt     <= N'(1) << arb_id;
                        q_enq_o <= ~req_op[arb_id];
                        q_deq_o <= req_op[arb_id];
                        q_key_o <= req_key[arb_id*W +: W];
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign issue_deq = (state == ISSUE) && win_op;

    // Response tags ride a shift register so results stay ordered for any RD_LAT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            id_hold  <= '0;
            key_hold <= '0;
        end else begin
            vld_pipe[1] <= issue_deq;
            id_pipe[1]  <= win_id;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
            if (rsp_valid) begin
                id_hold  <= id_pipe[RD_LAT];
                key_hold <= q_key_i;
            end
        end
    end

    assign rsp_valid = vld_pipe[RD_LAT];
    assign rsp_id    = rsp_valid ? id_pipe[RD_LAT] : id_hold;
    assign rsp_key   = rsp_valid ? q_key_i : key_hold;

endmodule

// File: doc/qq_port_arbiter.md
Name: qq_port_arbiter

Overview:
- Shares one quickq (chain of qq_node stages) among N requesters.
- Picks requesters round-robin and issues at most one enqueue or dequeue per GAP cycles at the root node, which is the spacing the node pipeline tolerates.
- Tracks total occupancy, so it never enqueues into a full queue or dequeues from an empty one.
- Returns dequeued keys, tagged with the requester ID, after a fixed read latency.

Parameters:
- W, 8, key width; matches the qq_node W.
- N, 4, number of requesters (≥2).
- CAP, 16, total queue capacity in entries.
- GAP, 2, minimum number of cycles between consecutive root operations (≥2).
- RD_LAT, 2, cycles from a dequeue ISSUE until the root's data_lt_o holds the dequeued key (≥1).
- IDW, $clog2(N), width of a requester ID.
- CW, $clog2(CAP+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; once raised, held until gnt.
- req_op  input  N  per-requester op: 0 = enqueue, 1 = dequeue.
- req_key  input  N*W  per-requester key; requester i uses bits [i*W +: W].
- gnt  output  N  one-hot, one-cycle pulse on the ISSUE cycle.
- q_enq_o  output  1  to root enq_i.
- q_deq_o  output  1  to root deq_i.
- q_key_o  output  W  to root data_lt_i.
- q_key_i  input  W  from root data_lt_o.
- rsp_valid  output  1  dequeue result valid, one-cycle pulse.
- rsp_id  output  IDW  requester that owns the result.
- rsp_key  output  W  dequeued key.
- count  output  CW  current occupancy.
- full  output  1  count == CAP.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; RR pointer = 0; count = 0.
  - The response pipeline is cleared and any in-flight responses are dropped.
  - gnt, q_enq_o, q_deq_o, q_key_o, rsp_valid, rsp_id and rsp_key are all 0; empty = 1; full = 0.
- Eligibility: requester i is eligible when req[i] is set and either req_op[i]=0 with full=0, or req_op[i]=1 with empty=0.
- Arbitration:
  - Search starts at the RR pointer and wraps modulo N; the first eligible requester wins.
  - At the arbitration edge, the winner ID, its op and its key are latched.
  - The pointer becomes winner+1 (mod N), updated only when a grant is made.
- FSM states: IDLE, ISSUE, COOL.
  - IDLE: arbitrate every cycle. If any requester is eligible → ISSUE; otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - gnt[winner]=1.
    - q_enq_o = ~op and q_deq_o = op; never both.
    - q_key_o = latched key; q_key_o is 0 outside ISSUE.
    - A cooldown counter is loaded with GAP-1; next state is COOL.
  - COOL:
    - The counter decrements each cycle.
    - On the cycle the counter reads 1, the block arbitrates. If there is a winner → ISSUE, otherwise → IDLE.
    - Result: with GAP=2 and continuous demand, an ISSUE occurs every 2 cycles.
- Occupancy:
  - count increments at the end of an enqueue ISSUE cycle and decrements at the end of a dequeue ISSUE cycle.
  - full and empty are decoded from the count register.
  - Arbitration always sees the count already updated by the previous ISSUE.
  - count never exceeds CAP and never underflows, because eligibility gating guarantees it.
- Response path:
  - A dequeue ISSUE at cycle t produces rsp_valid=1 at cycle t+RD_LAT.
  - On that cycle rsp_id = winner and rsp_key = q_key_i sampled that cycle.
  - Because GAP ≥ 2, responses never overlap when RD_LAT ≤ GAP; otherwise the shift-register pipeline preserves order.
  - rsp_id and rsp_key hold their last values when rsp_valid=0.
- Protocol boundaries:
  - A requester that drops req after it has won arbitration, but before its gnt, still receives its latched op.
  - Changing req_key while req is high is a requester-side violation; the latched key is used.
  - A requester whose op is blocked by full or empty waits and does not block other requesters (no head-of-line blocking).
- Simultaneous events: at most one op is issued per ISSUE, so enqueue and dequeue never coincide at the root.

Test Plan:
- Reset: hold rst=0 for 3 cycles while req=4'b1111 → gnt=0, q_enq_o=q_deq_o=0, count=0, empty=1, full=0, rsp_valid=0.
- Single enqueue: in IDLE, req[1]=1, req_op[1]=0, key 0x2A at cycle 0 → cycle 1: gnt=4'b0010, q_enq_o=1, q_key_o=0x2A. Cycle 2: count=1, empty=0.
- Round-robin: all 4 requesters enqueue continuously, GAP=2 → ISSUE cycles 1,3,5,7,9 grant requesters 0,1,2,3,0. count reaches 5; there are no idle gaps.
- Full: with CAP=4, after 4 enqueues, req0 enqueues and req2 dequeues → req2 is granted with q_deq_o=1 and req0 is not. rsp_valid rises RD_LAT=2 cycles after that ISSUE with rsp_id=2 and rsp_key equal to the bench-driven q_key_i (0x07). req0 is granted at the next ISSUE.
- Empty: after reset, req3 dequeues alone for 10 cycles → no gnt. req0 then enqueues 0x05 and is granted. At the next arbitration req3 is granted; rsp_key=0x05 and rsp_id=3.
- Reset mid-op: rst=0 one cycle after a dequeue ISSUE (in COOL) → rsp_valid never pulses, count=0, and the next grant goes to requester 0 first.
